// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: registered single-cycle ops plus an iterative
// shift-add multiplier behind a start/ready/done handshake.
module alu_seq_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;

    logic [WIDTH-1:0] op_res;
    logic             op_ill;
    logic             op_mul;
    logic [WIDTH-1:0] acc_next;
    logic [4:0]       sh;

    assign sh = b[4:0];

    always_comb begin
        op_res = '0;
        op_ill = 1'b0;
        op_mul = 1'b0;
        unique case (alu_operation)
            4'h0: op_res = a + b;
            4'h1: op_res = a - b;
            4'h2: op_res = a ^ b;
            4'h3: op_res = a | b;
            4'h4: op_res = a & b;
            4'h5,
            4'h7: op_res = a << sh;
            4'h6,
            4'h8: op_res = a >> sh;
            4'h9: op_res = {{(WIDTH-1){1'b0}},
                            ($signed(a) < $signed(b))};
            4'hA: op_mul = 1'b1;
            default: op_ill = 1'b1;
        endcase
    end

    // One shift-add step; also the final product on the last edge
    assign acc_next = mplier[0] ? acc + mcand : acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            done    <= 1'b0;
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (op_mul) begin
                            acc    <= '0;
                            mcand  <= a;
                            mplier <= b;
                            count  <= '0;
                            state  <= MUL;
                        end else begin
                            result  <= op_res;
                            zero    <= (op_res == '0);
                            illegal <= op_ill;
                            done    <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        result  <= acc_next;
                        zero    <= (acc_next == '0);
                        illegal <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end

    assign ready = (state == IDLE);
    assign busy  = (state == MUL);

endmodule

// File: tb/tb_alu_seq_exec.sv
// Bench for alu_seq_exec: vector table, scoreboard queue and
// hand-written multiply / reset sequences.
module tb_alu_seq_exec;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  alu_operation;
    logic [31:0] a;
    logic [31:0] b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    vec_t vt[16];

    alu_seq_exec #(.WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .alu_operation(alu_operation),
        .a(a),
        .b(b),
        .ready(ready),
        .busy(busy),
        .done(done),
        .result(result),
        .zero(zero),
        .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pops one expected record
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done actual=%h required=none",
                         result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (result !== e.res || zero !== e.z ||
                    illegal !== e.ill || ready !== 1'b1) begin
                    errors++;
                    $display("FAIL sb_result actual=%h/%b/%b/%b required=%h/%b/%b/1",
                             result, zero, illegal, ready,
                             e.res, e.z, e.ill);
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic push,
                         input logic [31:0] r, input logic z,
                         input logic il);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=%b required=1", ready);
        end
        start         = 1'b1;
        alu_operation = op;
        a             = x;
        b             = y;
        if (push) sb.push_back('{res: r, z: z, ill: il});
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 100);
    endtask

    initial begin
        int n;
        int bcnt;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] prod;

        vt[0]  = '{4'h0, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 0};
        vt[1]  = '{4'h1, 32'd5,        32'd7,        32'hFFFFFFFE, 0, 0};
        vt[2]  = '{4'h9, 32'h80000000, 32'h1,        32'h1,        0, 0};
        vt[3]  = '{4'h7, 32'h1,        32'h21,       32'h2,        0, 0};
        vt[4]  = '{4'h8, 32'h80000000, 32'd31,       32'h1,        0, 0};
        vt[5]  = '{4'h5, 32'h3,        32'h4,        32'h30,       0, 0};
        vt[6]  = '{4'h6, 32'hF0,       32'h4,        32'hF,        0, 0};
        vt[7]  = '{4'h2, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 0, 0};
        vt[8]  = '{4'h3, 32'h000000F0, 32'h00000F00, 32'h00000FF0, 0, 0};
        vt[9]  = '{4'h4, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 0, 0};
        vt[10] = '{4'h9, 32'h1,        32'h80000000, 32'h0,        1, 0};
        vt[11] = '{4'h9, 32'hFFFFFFFF, 32'h0,        32'h1,        0, 0};
        vt[12] = '{4'hB, 32'h1234,     32'h5678,     32'h0,        1, 1};
        vt[13] = '{4'hF, 32'hFFFF,     32'h1,        32'h0,        1, 1};
        vt[14] = '{4'h7, 32'h1234,     32'hFFFFFFE0, 32'h1234,     0, 0};
        vt[15] = '{4'h1, 32'd7,        32'd7,        32'h0,        1, 0};

        reset = 1'b0;
        start = 1'b1;
        alu_operation = 4'h0;
        a = 32'd1;
        b = 32'd1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_ready", {31'b0, ready}, 32'h1);
            chk("rst_busy", {31'b0, busy}, 32'h0);
            chk("rst_done", {31'b0, done}, 32'h0);
            chk("rst_result", result, 32'h0);
        end
        chk("rst_zero", {31'b0, zero}, 32'h0);
        chk("rst_illegal", {31'b0, illegal}, 32'h0);
        start = 1'b0;
        reset = 1'b1;

        // Back-to-back single-cycle ops
        for (int i = 0; i < 16; i++)
            issue(vt[i].op, vt[i].a, vt[i].b, 1'b1,
                  vt[i].res, vt[i].z, vt[i].ill);
        repeat (2) @(negedge clk);

        // Multiply latency and busy window
        issue(4'hA, 32'd12345, 32'd6789, 1'b1, 32'h04FED79D, 0, 0);
        n = 0;
        bcnt = 0;
        do begin
            @(negedge clk);
            n++;
            if (done !== 1'b1 && busy === 1'b1 && ready === 1'b0)
                bcnt++;
        end while (done !== 1'b1 && n < 100);
        chk("mul_latency", n, 33);
        chk("mul_busy_cycles", bcnt, 32);
        chk("mul_ready_at_done", {31'b0, ready}, 32'h1);

        issue(4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h1, 0, 0);
        wait_done(n);
        chk("mul_ff_latency", n, 33);

        issue(4'hA, 32'h0, 32'd5, 1'b1, 32'h0, 1, 0);
        wait_done(n);

        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            prod = ra * rb;
            issue(4'hA, ra, rb, 1'b1, prod, (prod == 0), 0);
            wait_done(n);
        end

        // Start pulses and operand churn during a multiply
        issue(4'hA, 32'd1000, 32'd3000, 1'b1, 32'd3000000, 0, 0);
        for (int i = 0; i < 20; i++) begin
            start = 1'b1;
            alu_operation = 4'h0;
            a = $urandom;
            b = $urandom;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        wait_done(n);
        chk("mul_ignore_latency", n, 13);
        repeat (3) @(negedge clk);
        chk("mul_result_held", result, 32'd3000000);
        chk("sb_drained_mid", sb.size(), 0);

        // Reset in the middle of a multiply
        issue(4'hA, 32'hDEAD, 32'hBEEF, 1'b0, 32'h0, 0, 0);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_ready", {31'b0, ready}, 32'h1);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_done", {31'b0, done}, 32'h0);
        chk("abort_result", result, 32'h0);
        chk("abort_zero", {31'b0, zero}, 32'h0);
        chk("abort_illegal", {31'b0, illegal}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'b0, done}, 32'h0);
        end
        reset = 1'b1;

        issue(4'h0, 32'd2, 32'd3, 1'b1, 32'd5, 0, 0);
        @(negedge clk);
        chk("post_rst_done", {31'b0, done}, 32'h1);
        issue(4'hC, 32'h55, 32'hAA, 1'b1, 32'h0, 1, 1);
        @(negedge clk);
        chk("illegal_done", {31'b0, done}, 32'h1);
        @(negedge clk);
        chk("done_one_cycle", {31'b0, done}, 32'h0);

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Execute-stage ALU that consumes the 4-bit ALU operation code produced by the ALU control decoder, plus two operands from the register file / immediate mux.
- Single-cycle ops complete with a registered result one cycle after acceptance.
- MUL runs on an iterative shift-add engine over WIDTH cycles.
- A start/ready/done handshake lets the core stall the PC while a multiply is in flight.

Parameters:
- WIDTH, 32, operand/result width; multiply iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (one clock; asserted = 0 clears all state immediately).
- start  in  1  request; accepted on a rising edge when start=1 and ready=1.
- alu_operation  in  4  op code from ALU control (encoding below).
- a  in  WIDTH  operand A (rs1 or PC).
- b  in  WIDTH  operand B (rs2 or immediate).
- ready  out  1  block can accept a request (state IDLE).
- busy  out  1  multiply in progress (state MUL).
- done  out  1  one-cycle pulse; result/zero/illegal valid.
- result  out  WIDTH  registered result, held until next done.
- zero  out  1  registered (result == 0), updated with result.
- illegal  out  1  registered; 1 when the accepted op code was not in the table.

Behaviour:
- Op encoding:
  - 0000 add; 0001 sub (a-b); 0010 xor; 0011 or; 0100 and.
  - 0101 and 0111 sll (a << b[4:0]); 0110 and 1000 srl logical (a >> b[4:0]).
  - 1001 slt signed (result 1 or 0); 1010 mul (low WIDTH bits of a*b, unsigned shift-add; low bits match signed).
  - 1011-1111 illegal: result=0, zero=1, illegal=1.
- Arithmetic wraps modulo 2^WIDTH; no overflow flag.
- Reset values: ready=1, busy=0, done=0, result=0, zero=0, illegal=0, state=IDLE, iteration counter=0, internal multiplicand/multiplier/accumulator=0.
- Operands and op are captured on the accept edge. Later changes on a/b/alu_operation have no effect on the in-flight operation.
- FSM states:
  - IDLE:
    - ready=1, busy=0.
    - Accept of a non-mul op: compute and register result/zero/illegal on the same edge, done=1 for the following cycle, stay IDLE.
    - Accept of mul: load accumulator=0, multiplicand=a, multiplier=b, count=0, go to MUL; done stays 0.
  - MUL:
    - ready=0, busy=1.
    - Each edge: if multiplier[0], accumulator += multiplicand; multiplicand <<= 1; multiplier >>= 1; count++.
    - On the edge where count reaches WIDTH-1 (WIDTH-th iteration): write final accumulator to result, update zero, illegal=0, done=1, return to IDLE.
- Latency, with accept edge = edge 0:
  - Non-mul: done high after edge 1 is not used; done is high in the cycle following edge 0.
  - Mul: done high in the cycle following edge WIDTH.
  - ready returns to 1 in the same cycle done is high.
- done is high for exactly one cycle. It deasserts on the next edge unless a new single-cycle op is accepted in the done cycle; back-to-back accepts are allowed and give a continuous done.
- start while ready=0 is ignored (not queued); result is not disturbed.
- Reset asserted mid-multiply: aborts immediately, all outputs return to reset values, and no done pulse is produced.
- Shifts use only b[4:0]; b[WIDTH-1:5] is ignored. Shift by 0 returns a.
- The zero flag is the branch-compare source (sub result == 0). Downstream branch logic samples it only when done=1.

Test Plan:
- Reset: hold reset=0 two cycles with start=1 -> ready=1, busy=0, done=0, result=0 throughout; no accept.
- add/sub/slt: accept add a=0xFFFFFFFF b=1 -> next cycle done=1, result=0, zero=1. Then sub a=5 b=7 -> result=0xFFFFFFFE, zero=0. Then slt a=0x80000000 b=1 -> result=1.
- Shifts: op 0111 a=0x1 b=0x21 -> result=0x2 (only b[4:0]=1 used). Op 1000 a=0x80000000 b=31 -> result=0x1.
- Multiply: mul a=12345 b=6789 -> busy=1 for 32 cycles, ready=0, done exactly 32 edges after accept, result=83810205 (0x04FED79D). Mul a=0xFFFFFFFF b=0xFFFFFFFF -> result=0x00000001.
- Ignored start / operand change: during a multiply, pulse start with add and change a/b every cycle -> no extra done, the multiply result is unchanged, and the add is not executed afterwards.
- Reset mid-operation: assert reset=0 at iteration 10 of mul -> outputs go to reset values immediately. After release, add a=2 b=3 -> done one cycle later, result=5. Illegal op 1100 -> result=0, zero=1, illegal=1.
